// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline host command sequencer: opcodes,
// 4-bit FSM state encoding (as reported in status_reg[27:24]) and
// status_reg bit positions.
package pipe_ctrl_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOP     = 3'd0;
  localparam opcode_t OP_WR_IMEM = 3'd1;
  localparam opcode_t OP_WR_DMEM = 3'd2;
  localparam opcode_t OP_RD_IMEM = 3'd3;
  localparam opcode_t OP_RD_DMEM = 3'd4;
  localparam opcode_t OP_RUN     = 3'd5;
  localparam opcode_t OP_HALT    = 3'd6;
  localparam opcode_t OP_FLUSH   = 3'd7;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR      = 4'd1;
  localparam logic [3:0] ST_RD_ADDR = 4'd2;
  localparam logic [3:0] ST_RD_DATA = 4'd3;
  localparam logic [3:0] ST_RUN     = 4'd4;
  localparam logic [3:0] ST_DRAIN   = 4'd5;
  localparam logic [3:0] ST_FLUSH   = 4'd6;

  localparam int STAT_DONE      = 31;
  localparam int STAT_BUSY      = 30;
  localparam int STAT_ERR       = 29;
  localparam int STAT_TIMEOUT   = 28;
  localparam int STAT_STATE_LSB = 24;
  localparam int CNT_W          = 24;

  // Data-memory accesses select dmem; everything else targets imem.
  function automatic logic op_is_dmem(input opcode_t op);
    return (op == OP_WR_DMEM) || (op == OP_RD_DMEM);
  endfunction

endpackage

// File: rtl/pipe_mem_cmd_ctrl_if.sv
// Shared instruction/data memory port between the host sequencer (master)
// and the memory (slave).
interface pipe_mem_cmd_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();
  logic              mem_host_sel;
  logic              mem_en;
  logic              mem_we;
  logic              mem_dsel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_host_sel, mem_en, mem_we, mem_dsel, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_host_sel, mem_en, mem_we, mem_dsel, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pipe_run_counter.sv
// Saturating RUN-cycle counter with watchdog compare. Only instantiated
// when MEM_CTRL_CYCLE_CNT_EN is defined.
module pipe_run_counter #(
  parameter int                    CNT_W = 24,
  parameter logic [CNT_W-1:0]      LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  localparam logic [CNT_W-1:0] LIMIT_M1 = LIMIT - CNT_W'(1);

  // The increment that brings the count up to LIMIT is the expiring cycle.
  assign expire = inc && (count >= LIMIT_M1);

  // Count RUN cycles from zero, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/pipe_mem_cmd_ctrl.sv
// Host command sequencer: decodes toggle-qualified software commands into
// single-cycle memory accesses, runs/halts/drains the pipeline and owns the
// shared memory port except while the pipeline runs or drains.
// Optional RUN-cycle counter and watchdog: MEM_CTRL_CYCLE_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for a command toggle
// WR       | one-cycle host write
// RD_ADDR  | host read, address phase
// RD_DATA  | host read, capture memory data
// RUN      | pipeline advancing, pipeline owns memory
// DRAIN    | pipeline stopped, DRAIN_CYC cycles before release
// FLUSH    | one-cycle pipeline register clear
module pipe_mem_cmd_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 32,
  parameter int          DRAIN_CYC = 5,
  parameter logic [23:0] RUN_LIMIT = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         mem_cmd_reg,
  input  logic [31:0]         mem_addr_reg,
  input  logic [31:0]         mem_data_write_reg,
  output logic [31:0]         mem_data_read_reg,
  output logic [31:0]         status_reg,
  pipe_mem_cmd_ctrl_if.master mem,
  output logic                pipe_run,
  output logic                pipe_flush,
  input  logic                pipe_halted
);
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  logic [3:0]        state;
  logic              seq_q, done_seq, err, timeout_q, dsel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DRN_W-1:0]  drain_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic              wdog_exp, new_cmd, busy, halt_req, run_exit, drop;
  opcode_t           op;

  assign op       = mem_cmd_reg[2:0];
  assign new_cmd  = mem_cmd_reg[31] ^ seq_q;
  assign busy     = (state != ST_IDLE);
  assign halt_req = new_cmd && (op == OP_HALT) && (state == ST_RUN);
  // pipe_halted and a HALT command in the same cycle form a single exit.
  assign run_exit = (state == ST_RUN) && (pipe_halted || halt_req || wdog_exp);
  assign drop     = new_cmd && busy && !halt_req;

`ifdef MEM_CTRL_CYCLE_CNT_EN
  logic run_start;
  assign run_start = (state == ST_IDLE) && new_cmd && (op == OP_RUN);

  pipe_run_counter #(.CNT_W(CNT_W), .LIMIT(RUN_LIMIT)) u_run_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (run_start),
    .inc    (state == ST_RUN),
    .count  (run_cnt),
    .expire (wdog_exp)
  );
`else
  logic unused_run_limit;
  assign unused_run_limit = ^RUN_LIMIT;
  assign run_cnt  = '0;
  assign wdog_exp = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{mem_cmd_reg[30:3], mem_addr_reg[31:ADDR_W]};

  // Command sequencing, sticky error/timeout flags and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      seq_q             <= 1'b0;
      done_seq          <= 1'b0;
      err               <= 1'b0;
      timeout_q         <= 1'b0;
      dsel_q            <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      drain_cnt         <= '0;
      mem_data_read_reg <= '0;
    end else begin
      if (new_cmd) seq_q <= mem_cmd_reg[31];
      if (drop) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (new_cmd) begin
            if ((op == OP_WR_IMEM) || (op == OP_WR_DMEM) ||
                (op == OP_RD_IMEM) || (op == OP_RD_DMEM)) begin
              addr_q  <= mem_addr_reg[ADDR_W-1:0];
              wdata_q <= mem_data_write_reg[DATA_W-1:0];
              dsel_q  <= op_is_dmem(op);
            end
            case (op)
              OP_NOP: begin
                err       <= 1'b0;
                timeout_q <= 1'b0;
                done_seq  <= mem_cmd_reg[31];
              end
              OP_WR_IMEM, OP_WR_DMEM: state <= ST_WR;
              OP_RD_IMEM, OP_RD_DMEM: state <= ST_RD_ADDR;
              OP_RUN:                 state <= ST_RUN;
              OP_FLUSH:               state <= ST_FLUSH;
              default:                done_seq <= mem_cmd_reg[31];
            endcase
          end
        end
        ST_WR, ST_FLUSH: begin
          state    <= ST_IDLE;
          done_seq <= seq_q;
        end
        ST_RD_ADDR: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          mem_data_read_reg <= 32'(mem.mem_rdata);
          state             <= ST_IDLE;
          done_seq          <= seq_q;
        end
        ST_RUN: begin
          if (run_exit) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRN_W'(DRAIN_CYC - 1);
            if (wdog_exp) timeout_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= ST_IDLE;
            done_seq <= seq_q;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_host_sel = !((state == ST_RUN) || (state == ST_DRAIN));
  assign mem.mem_en       = (state == ST_WR) || (state == ST_RD_ADDR);
  assign mem.mem_we       = (state == ST_WR);
  assign mem.mem_dsel     = dsel_q;
  assign mem.mem_addr     = addr_q;
  assign mem.mem_wdata    = wdata_q;
  assign pipe_run         = (state == ST_RUN);
  assign pipe_flush       = (state == ST_FLUSH);

  // Assemble the status word from the named bit positions.
  always_comb begin
    status_reg                          = '0;
    status_reg[STAT_DONE]               = done_seq;
    status_reg[STAT_BUSY]               = busy;
    status_reg[STAT_ERR]                = err;
    status_reg[STAT_TIMEOUT]            = timeout_q;
    status_reg[STAT_STATE_LSB +: 4]     = state;
    status_reg[CNT_W-1:0]               = run_cnt;
  end
endmodule

// File: tb/tb_pipe_mem_cmd_ctrl.sv
// Self-checking bench for pipe_mem_cmd_ctrl with a transaction-level
// reference model of memory contents and command completion.
module tb_pipe_mem_cmd_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_cmd_reg = '0, mem_addr_reg = '0, mem_data_write_reg = '0;
  logic [31:0] mem_data_read_reg, status_reg;
  logic        pipe_run, pipe_flush;
  logic        pipe_halted = 1'b0;

  int checks = 0;
  int failures = 0;

  pipe_mem_cmd_ctrl_if #(.ADDR_W(9), .DATA_W(32)) mem_bus ();

  pipe_mem_cmd_ctrl #(.ADDR_W(9), .DATA_W(32), .DRAIN_CYC(5), .RUN_LIMIT(24'd100)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_cmd_reg        (mem_cmd_reg),
    .mem_addr_reg       (mem_addr_reg),
    .mem_data_write_reg (mem_data_write_reg),
    .mem_data_read_reg  (mem_data_read_reg),
    .status_reg         (status_reg),
    .mem                (mem_bus),
    .pipe_run           (pipe_run),
    .pipe_flush         (pipe_flush),
    .pipe_halted        (pipe_halted)
  );

  always #5 clk = ~clk;

  // Memory environment plus activity monitors
  logic [31:0] mem_i [512];
  logic [31:0] mem_d [512];
  int          wr_seen = 0, run_seen = 0, drain_seen = 0, flush_seen = 0;
  logic [8:0]  last_waddr = '0;
  logic        last_wdsel = 1'b0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) begin
        mem_i[i] <= '0;
        mem_d[i] <= '0;
      end
      mem_bus.mem_rdata <= '0;
    end else begin
      if (mem_bus.mem_en && mem_bus.mem_we) begin
        wr_seen    <= wr_seen + 1;
        last_waddr <= mem_bus.mem_addr;
        last_wdsel <= mem_bus.mem_dsel;
        last_wdata <= mem_bus.mem_wdata;
        if (mem_bus.mem_dsel) mem_d[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        else                  mem_i[mem_bus.mem_addr] <= mem_bus.mem_wdata;
      end
      if (mem_bus.mem_en && !mem_bus.mem_we)
        mem_bus.mem_rdata <= mem_bus.mem_dsel ? mem_d[mem_bus.mem_addr] : mem_i[mem_bus.mem_addr];
      if (pipe_run) run_seen <= run_seen + 1;
      if (!mem_bus.mem_host_sel && !pipe_run) drain_seen <= drain_seen + 1;
      if (pipe_flush) flush_seen <= flush_seen + 1;
    end
  end

  // Reference model state
  logic [31:0] ref_i [512];
  logic [31:0] ref_d [512];
  logic        cmd_tgl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 512; i++) begin
      ref_i[i] = '0;
      ref_d[i] = '0;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [8:0] a, input logic [31:0] d);
    cmd_tgl            = !cmd_tgl;
    mem_addr_reg       = {23'($urandom), a};
    mem_data_write_reg = d;
    mem_cmd_reg        = {cmd_tgl, 28'($urandom), op};
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (status_reg[30] && n < budget) begin
      step(1);
      n++;
    end
    chk("idle_wait", {31'b0, status_reg[30]}, 32'd0);
  endtask

  // Command issued from IDLE, checked for latency and effect
  task automatic do_cmd(input logic [2:0] op, input logic [8:0] a, input logic [31:0] d);
    int lat, w0, f0;
    bit is_wr, is_rd;
    is_wr = (op == OP_WR_IMEM) || (op == OP_WR_DMEM);
    is_rd = (op == OP_RD_IMEM) || (op == OP_RD_DMEM);
    lat   = is_wr ? 2 : is_rd ? 3 : (op == OP_FLUSH) ? 2 : 1;
    w0 = wr_seen;
    f0 = flush_seen;
    send(op, a, d);
    if (lat > 1) begin
      step(lat - 1);
      chk("done_early", {31'b0, status_reg[31]}, {31'b0, !cmd_tgl});
    end
    step(1);
    chk("done_seq", {31'b0, status_reg[31]}, {31'b0, cmd_tgl});
    chk("busy_end", {31'b0, status_reg[30]}, 32'd0);
    chk("wr_count", wr_seen - w0, is_wr ? 32'd1 : 32'd0);
    if (is_wr) begin
      if (op == OP_WR_DMEM) ref_d[a] = d; else ref_i[a] = d;
      chk("wr_addr", {23'b0, last_waddr}, {23'b0, a});
      chk("wr_dsel", {31'b0, last_wdsel}, (op == OP_WR_DMEM) ? 32'd1 : 32'd0);
      chk("wr_data", last_wdata, d);
    end
    if (is_rd)
      chk("rd_data", mem_data_read_reg, (op == OP_RD_DMEM) ? ref_d[a] : ref_i[a]);
    if (op == OP_FLUSH) chk("flush_count", flush_seen - f0, 32'd1);
    if (op == OP_NOP) chk("nop_timeout", {31'b0, status_reg[28]}, 32'd0);
    chk("err", {31'b0, status_reg[29]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int r0, d0, w0, n, r;
    logic [2:0] op;
    logic [8:0] a;
    ref_clear();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_status", status_reg, 32'd0);
    chk("rst_host_sel", {31'b0, mem_bus.mem_host_sel}, 32'd1);
    chk("rst_pipe_run", {31'b0, pipe_run}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_bus.mem_en}, 32'd0);
    chk("rst_rd_data", mem_data_read_reg, 32'd0);
    #10 rst_n = 1'b1;
    step(2);
    chk("post_rst_idle", status_reg, 32'd0);

    do_cmd(OP_WR_DMEM, 9'h010, 32'hDEADBEEF);
    do_cmd(OP_RD_DMEM, 9'h010, 32'h0);
    chk("rd_deadbeef", mem_data_read_reg, 32'hDEADBEEF);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 6);
      op = (r < 5) ? 3'(r) : ((r == 5) ? OP_FLUSH : OP_HALT);
      a  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
      do_cmd(op, a, $urandom);
      step($urandom_range(0, 2));
    end

    // RUN ended by pipe_halted after 20 cycles
    r0 = run_seen;
    d0 = drain_seen;
    send(OP_RUN, 9'h0, 32'h0);
    step(1);
    chk("run_state", {28'b0, status_reg[27:24]}, {28'b0, ST_RUN});
    chk("run_pipe_run", {31'b0, pipe_run}, 32'd1);
    chk("run_host_sel", {31'b0, mem_bus.mem_host_sel}, 32'd0);
    step(19);
    pipe_halted = 1'b1;
    step(1);
    chk("drain_state", {28'b0, status_reg[27:24]}, {28'b0, ST_DRAIN});
    chk("drain_pipe_run", {31'b0, pipe_run}, 32'd0);
    chk("drain_host_sel", {31'b0, mem_bus.mem_host_sel}, 32'd0);
    wait_idle(20);
    pipe_halted = 1'b0;
    chk("run_cycles", run_seen - r0, 32'd20);
    chk("drain_cycles", drain_seen - d0, 32'd5);
    chk("idle_host_sel", {31'b0, mem_bus.mem_host_sel}, 32'd1);
    chk("run_done_seq", {31'b0, status_reg[31]}, {31'b0, cmd_tgl});
`ifdef MEM_CTRL_CYCLE_CNT_EN
    chk("run_count", {8'b0, status_reg[23:0]}, 32'd20);
`else
    chk("run_count", {8'b0, status_reg[23:0]}, 32'd0);
`endif

    // Write dropped while running, HALT command exits, NOP clears err
    send(OP_RUN, 9'h0, 32'h0);
    step(5);
    w0 = wr_seen;
    send(OP_WR_IMEM, 9'h003, 32'h12345678);
    step(1);
    chk("drop_err", {31'b0, status_reg[29]}, 32'd1);
    chk("drop_still_run", {31'b0, pipe_run}, 32'd1);
    step(3);
    chk("drop_no_write", wr_seen - w0, 32'd0);
    send(OP_HALT, 9'h0, 32'h0);
    step(1);
    chk("halt_cmd_drain", {28'b0, status_reg[27:24]}, {28'b0, ST_DRAIN});
    wait_idle(20);
    chk("err_sticky", {31'b0, status_reg[29]}, 32'd1);
    chk("halt_done_seq", {31'b0, status_reg[31]}, {31'b0, cmd_tgl});
    do_cmd(OP_NOP, 9'h0, 32'h0);
    do_cmd(OP_RD_IMEM, 9'h003, 32'h0);

    // HALT together with pipe_halted, then HALT during DRAIN
    send(OP_RUN, 9'h0, 32'h0);
    step(4);
    send(OP_HALT, 9'h0, 32'h0);
    pipe_halted = 1'b1;
    step(1);
    chk("dual_exit_drain", {28'b0, status_reg[27:24]}, {28'b0, ST_DRAIN});
    chk("dual_exit_err", {31'b0, status_reg[29]}, 32'd0);
    send(OP_HALT, 9'h0, 32'h0);
    step(1);
    pipe_halted = 1'b0;
    chk("halt_in_drain_err", {31'b0, status_reg[29]}, 32'd1);
    wait_idle(20);
    chk("drain_done_seq", {31'b0, status_reg[31]}, {31'b0, cmd_tgl});
    do_cmd(OP_NOP, 9'h0, 32'h0);

    // Watchdog
    r0 = run_seen;
    send(OP_RUN, 9'h0, 32'h0);
    step(1);
`ifdef MEM_CTRL_CYCLE_CNT_EN
    n = 0;
    while (pipe_run && n < 300) begin
      step(1);
      n++;
    end
    chk("wdog_run_cycles", run_seen - r0, 32'd100);
    chk("wdog_timeout", {31'b0, status_reg[28]}, 32'd1);
    chk("wdog_count", {8'b0, status_reg[23:0]}, 32'd100);
    wait_idle(20);
    chk("wdog_timeout_held", {31'b0, status_reg[28]}, 32'd1);
`else
    step(150);
    chk("no_wdog_run", {31'b0, pipe_run}, 32'd1);
    chk("no_wdog_timeout", {31'b0, status_reg[28]}, 32'd0);
    chk("no_wdog_count", {8'b0, status_reg[23:0]}, 32'd0);
    send(OP_HALT, 9'h0, 32'h0);
    step(1);
    wait_idle(20);
`endif
    do_cmd(OP_NOP, 9'h0, 32'h0);

    // Reset in the middle of RUN
    do_cmd(OP_RD_DMEM, 9'h010, 32'h0);
    send(OP_RUN, 9'h0, 32'h0);
    step(6);
    chk("pre_rst_run", {31'b0, pipe_run}, 32'd1);
    rst_n       = 1'b0;
    cmd_tgl     = 1'b0;
    mem_cmd_reg = '0;
    #1;
    chk("mid_rst_pipe_run", {31'b0, pipe_run}, 32'd0);
    chk("mid_rst_status", status_reg, 32'd0);
    chk("mid_rst_host_sel", {31'b0, mem_bus.mem_host_sel}, 32'd1);
    chk("mid_rst_rd_data", mem_data_read_reg, 32'd0);
    step(2);
    rst_n = 1'b1;
    ref_clear();
    step(2);
    chk("post_mid_rst_idle", status_reg, 32'd0);
    do_cmd(OP_WR_IMEM, 9'h1FF, 32'hA5A55A5A);
    do_cmd(OP_RD_IMEM, 9'h1FF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
